mc_bus_sender: RTL and testbench

MC_BUS_SENDER -- requirements
Module: mc_bus_sender

---
 rtl/mc_bus_pkg.sv | 19 +
 rtl/mc_sync_fifo.sv | 65 ++++++
 rtl/mc_bus_sender.sv | 151 +++++++++++++++
 tb/tb_mc_bus_sender.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_bus_pkg.sv
// Shared types and default widths for the multicast bus sender and its
// multicast_ctrl users.
package mc_bus_pkg;

   localparam int DEPTH_DEFAULT  = 4;
   localparam int TAG_W_DEFAULT  = 6;
   localparam int DATA_W_DEFAULT = 32;

   typedef struct packed {
      logic [TAG_W_DEFAULT-1:0]  tag;
      logic [DATA_W_DEFAULT-1:0] value;
   } mc_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } send_state_e;

endpackage

// File: rtl/mc_sync_fifo.sv
// Synchronous FIFO with extended pointers (MSB distinguishes full from empty).
// Exposes the head and the entry behind it so the sender can issue back-to-back beats.
module mc_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 38
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [WIDTH-1:0]         next_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [AW-1:0]    rdNext;
   logic             doPush;
   logic             doPop;

   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign count_o = wr_q - rd_q;
   assign doPush  = push_i && !full_o && !flush_i;
   assign doPop   = pop_i && !empty_o && !flush_i;
   assign rdNext  = rd_q[AW-1:0] + AW'(1);
   assign head_o  = mem_q[rd_q[AW-1:0]];
   assign next_o  = mem_q[rdNext];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (doPush) wr_d = wr_q + (AW+1)'(1);
         if (doPop)  rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: it is only ever read behind a valid pointer.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/mc_bus_sender.sv
// Multicast bus sender: queues {tag, value} entries and issues them as bus beats.
// Optional MC_BUS_SENDER_STATS_EN adds a 16-bit beat_count output.
module mc_bus_sender
   import mc_bus_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int TAG_W  = TAG_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [DATA_W-1:0] in_value,
   input  logic              flush,
   output logic [TAG_W-1:0]  Tag_to_Bus,
   output logic [DATA_W-1:0] value_to_Bus,
   output logic              Enable_to_Bus,
   input  logic              Ready_from_Bus,
   output logic              busy
`ifdef MC_BUS_SENDER_STATS_EN
   ,
   output logic [15:0]       beat_count
`endif
);

   localparam int EW = TAG_W + DATA_W;
   localparam int CW = $clog2(DEPTH) + 1;

   send_state_e       state_q, state_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [DATA_W-1:0] value_q, value_d;

   logic [EW-1:0]     fifoHead;
   logic [EW-1:0]     fifoNext;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [CW-1:0]     fifoCount;
   logic              pushAcc;
   logic              transfer;
   logic              moreQueued;

   assign in_ready      = !fifoFull;
   assign pushAcc       = in_valid && in_ready;
   assign Enable_to_Bus = (state_q == SEND);
   assign transfer      = Enable_to_Bus && Ready_from_Bus;
   assign moreQueued    = (fifoCount >= CW'(2));
   assign busy          = !fifoEmpty || (state_q == SEND);
   assign Tag_to_Bus    = Enable_to_Bus ? tag_q : '0;
   assign value_to_Bus  = Enable_to_Bus ? value_q : '0;

   // The beat on the bus stays at the FIFO head until it transfers, so the
   // in-flight entry still occupies a slot and in_ready reflects it.
   mc_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (flush),
      .push_i  (pushAcc),
      .wdata_i ({in_tag, in_value}),
      .pop_i   (transfer),
      .head_o  (fifoHead),
      .next_o  (fifoNext),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (!fifoEmpty || pushAcc) state_d = SEND;
            SEND: if (transfer && !moreQueued && !pushAcc) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A push into an empty queue is loaded straight from the inputs to get
   // single-cycle latency; the same entry is also written into the FIFO.
   always_comb begin
      tag_d   = tag_q;
      value_d = value_q;
      if (flush) begin
         tag_d   = '0;
         value_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifoEmpty) begin
                  {tag_d, value_d} = fifoHead;
               end else if (pushAcc) begin
                  tag_d   = in_tag;
                  value_d = in_value;
               end
            end
            SEND: begin
               if (transfer) begin
                  if (moreQueued) begin
                     {tag_d, value_d} = fifoNext;
                  end else if (pushAcc) begin
                     tag_d   = in_tag;
                     value_d = in_value;
                  end else begin
                     tag_d   = '0;
                     value_d = '0;
                  end
               end
            end
            default: begin
               tag_d   = '0;
               value_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tag_q   <= '0;
         value_q <= '0;
      end else begin
         tag_q   <= tag_d;
         value_q <= value_d;
      end
   end

`ifdef MC_BUS_SENDER_STATS_EN
   logic [15:0] beat_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         beat_q <= '0;
      else if (flush)    beat_q <= '0;
      else if (transfer) beat_q <= beat_q + 16'd1;
   end

   assign beat_count = beat_q;
`endif

endmodule

// File: tb/tb_mc_bus_sender.sv
// Self-checking bench for mc_bus_sender: directed scenarios plus random traffic
// checked against a queue-based model.
module tb_mc_bus_sender;
   import mc_bus_pkg::*;

   localparam int DEPTH = DEPTH_DEFAULT;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_tag = '0;
   logic [31:0] in_value = '0;
   logic        flush = 1'b0;
   logic [5:0]  Tag_to_Bus;
   logic [31:0] value_to_Bus;
   logic        Enable_to_Bus;
   logic        Ready_from_Bus = 1'b0;
   logic        busy;
`ifdef MC_BUS_SENDER_STATS_EN
   logic [15:0] beat_count;
`endif

   int compareCount = 0;
   int mismatchCount = 0;

   // Model: every accepted entry sits in modelQ until it transfers; the bus
   // shows modelQ[0] whenever the queue holds anything.
   mc_entry_t modelQ[$];
   int        modelBeats = 0;

   always #5 clk = ~clk;

   mc_bus_sender dut (
      .clk            (clk),
      .rstn           (rstn),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_tag         (in_tag),
      .in_value       (in_value),
      .flush          (flush),
      .Tag_to_Bus     (Tag_to_Bus),
      .value_to_Bus   (value_to_Bus),
      .Enable_to_Bus  (Enable_to_Bus),
      .Ready_from_Bus (Ready_from_Bus),
      .busy           (busy)
`ifdef MC_BUS_SENDER_STATS_EN
      ,
      .beat_count     (beat_count)
`endif
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         mismatchCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      mc_entry_t head;
      logic      expEn;
      expEn = (modelQ.size() > 0);
      head  = expEn ? modelQ[0] : '0;
      check({name, ".en"},    Enable_to_Bus, expEn);
      check({name, ".tag"},   Tag_to_Bus, head.tag);
      check({name, ".value"}, value_to_Bus, head.value);
      check({name, ".busy"},  busy, expEn);
      check({name, ".ready"}, in_ready, modelQ.size() < DEPTH);
`ifdef MC_BUS_SENDER_STATS_EN
      check({name, ".beats"}, beat_count, modelBeats % 65536);
`endif
   endtask

   // Drive one cycle of inputs, advance the model at the edge, then check.
   task automatic applyStimulus(input logic v, input logic [5:0] t, input logic [31:0] d,
                                input logic r, input logic f, input string name);
      int preSize;
      in_valid       = v;
      in_tag         = t;
      in_value       = d;
      Ready_from_Bus = r;
      flush          = f;
      @(posedge clk);
      preSize = modelQ.size();
      if (f) begin
         modelQ.delete();
         modelBeats = 0;
      end else begin
         if (preSize > 0 && r) begin
            void'(modelQ.pop_front());
            modelBeats++;
         end
         if (v && preSize < DEPTH) modelQ.push_back('{tag: t, value: d});
      end
      #1;
      checkOutput(name);
   endtask

   initial begin
      logic [5:0]  savedTag;
      logic [31:0] savedValue;
      int          guard;

      // Reset state
      #12;
      check("rst.en", Enable_to_Bus, 1'b0);
      check("rst.tag", Tag_to_Bus, 6'd0);
      check("rst.value", value_to_Bus, 32'd0);
      check("rst.busy", busy, 1'b0);
      check("rst.ready", in_ready, 1'b1);
      @(negedge clk);
      rstn = 1'b1;

      // Single entry, single-cycle latency
      applyStimulus(1, 6'd5, 32'hDEADBEEF, 1, 0, "single.push");
      check("single.en", Enable_to_Bus, 1'b1);
      check("single.tag", Tag_to_Bus, 6'd5);
      check("single.value", value_to_Bus, 32'hDEADBEEF);
      applyStimulus(0, 6'd0, 32'd0, 1, 0, "single.drain");
      check("single.en_after", Enable_to_Bus, 1'b0);
      check("single.busy_after", busy, 1'b0);

      // Fill to full, refuse fifth push, drain back-to-back
      for (int i = 1; i <= 4; i++)
         applyStimulus(1, 6'(i), 32'h100 + 32'(i), 0, 0, "fill.push");
      check("fill.ready_full", in_ready, 1'b0);
      applyStimulus(1, 6'd9, 32'h999, 0, 0, "fill.refused");
      check("fill.head", Tag_to_Bus, 6'd1);
      for (int i = 2; i <= 4; i++) begin
         applyStimulus(0, 6'd0, 32'd0, 1, 0, "fill.drain");
         check("fill.beat_en", Enable_to_Bus, 1'b1);
         check("fill.beat_tag", Tag_to_Bus, 6'(i));
      end
      applyStimulus(0, 6'd0, 32'd0, 1, 0, "fill.last");
      check("fill.empty_en", Enable_to_Bus, 1'b0);

      // Hold stable under back-pressure
      applyStimulus(1, 6'd33, 32'hCAFEF00D, 0, 0, "hold.push");
      savedTag   = Tag_to_Bus;
      savedValue = value_to_Bus;
      check("hold.tag0", savedTag, 6'd33);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 6'd0, 32'd0, 0, 0, "hold.wait");
         check("hold.tag", Tag_to_Bus, 6'd33);
         check("hold.value", value_to_Bus, 32'hCAFEF00D);
      end
      applyStimulus(0, 6'd0, 32'd0, 1, 0, "hold.xfer");
      check("hold.done", Enable_to_Bus, 1'b0);

      // Flush wins over a same-cycle push
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 6'(20 + i), $urandom, 0, 0, "flush.fill");
      applyStimulus(1, 6'd40, 32'h4040, 1, 1, "flush.go");
      check("flush.en", Enable_to_Bus, 1'b0);
      check("flush.busy", busy, 1'b0);
      check("flush.ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 6'd0, 32'd0, 1, 0, "flush.after");

      // Asynchronous reset mid-beat
      applyStimulus(1, 6'd7, 32'h7777, 0, 0, "arst.push0");
      applyStimulus(1, 6'd8, 32'h8888, 0, 0, "arst.push1");
      #2;
      rstn = 1'b0;
      #1;
      check("arst.en", Enable_to_Bus, 1'b0);
      check("arst.tag", Tag_to_Bus, 6'd0);
      check("arst.value", value_to_Bus, 32'd0);
      check("arst.busy", busy, 1'b0);
      check("arst.ready", in_ready, 1'b1);
      modelQ.delete();
      modelBeats = 0;
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 6'd0, 32'd0, 1, 0, "arst.after");

      // Random traffic
      for (int i = 0; i < 400; i++)
         applyStimulus($urandom_range(0, 99) < 60, 6'($urandom), $urandom,
                       $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3, "rand");

`ifdef MC_BUS_SENDER_STATS_EN
      // Counter wrap: 0x10001 transfers leave beat_count at 1
      applyStimulus(0, 6'd0, 32'd0, 0, 1, "stats.clear");
      guard = 0;
      while (modelBeats < 32'h10001 && guard < 70000) begin
         applyStimulus(1, 6'($urandom), $urandom, 1, 0, "stats.run");
         guard++;
      end
      check("stats.wrap", beat_count, 16'd1);
      applyStimulus(0, 6'd0, 32'd0, 0, 1, "stats.flush");
      check("stats.flushed", beat_count, 16'd0);
`else
      guard = 0;
      savedTag = '0;
      savedValue = '0;
      if (guard != 0 || savedTag != 0 || savedValue != 0) $display("[TB] unused");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
